// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, fill FSM states and the {y,x} address packing.
package fb_pkg;
  localparam int FB_X_W    = 8;
  localparam int FB_Y_W    = 7;
  localparam int FB_ADDR_W = FB_Y_W + FB_X_W;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} fb_state_t;

  function automatic logic [FB_ADDR_W-1:0] fb_pack(input logic [FB_Y_W-1:0] y,
                                                   input logic [FB_X_W-1:0] x);
    return {y, x};
  endfunction
endpackage

// File: rtl/fb_rect_walker.sv
// Rectangle raster walker: latches normalised bounds and steps an x/y cursor.
module fb_rect_walker
  import fb_pkg::*;
(
  input  logic                 gclk,
  input  logic                 grst_n,
  input  logic                 load,
  input  logic                 advance,
  input  logic [FB_X_W-1:0]    x0,
  input  logic [FB_X_W-1:0]    x1,
  input  logic [FB_Y_W-1:0]    y0,
  input  logic [FB_Y_W-1:0]    y1,
  output logic [FB_ADDR_W-1:0] addr,
  output logic                 last
);
  logic [FB_X_W-1:0] xmin, xmax, x;
  logic [FB_Y_W-1:0] ymin, ymax, y;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      xmin <= '0; xmax <= '0; ymin <= '0; ymax <= '0;
      x    <= '0; y    <= '0;
    end else if (load) begin
      // corners may arrive in any order
      xmin <= (x0 < x1) ? x0 : x1;
      xmax <= (x0 < x1) ? x1 : x0;
      ymin <= (y0 < y1) ? y0 : y1;
      ymax <= (y0 < y1) ? y1 : y0;
      x    <= (x0 < x1) ? x0 : x1;
      y    <= (y0 < y1) ? y0 : y1;
    end else if (advance) begin
      if (x == xmax) begin
        x <= xmin;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign addr = fb_pack(y, x);
  assign last = (x == xmax) && (y == ymax);
endmodule

// File: rtl/fb_rect_fill_ctrl.sv
// Port-A sequencer: rectangle fill engine sharing the port with a host pixel
// port; host has priority, bounded by HOST_MAX_BURST grants per fill slot.
module fb_rect_fill_ctrl
  import fb_pkg::*;
#(
  parameter int HOST_MAX_BURST = 4
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [FB_X_W-1:0]    CMD_X0,
  input  logic [FB_X_W-1:0]    CMD_X1,
  input  logic [FB_Y_W-1:0]    CMD_Y0,
  input  logic [FB_Y_W-1:0]    CMD_Y1,
  input  logic                 CMD_COLOUR,
  output logic                 BUSY,
  output logic                 DONE,
  input  logic                 HOST_REQ,
  input  logic                 HOST_WE,
  input  logic [FB_ADDR_W-1:0] HOST_ADDR,
  input  logic                 HOST_DIN,
  output logic                 HOST_GNT,
  output logic                 HOST_DOUT,
  output logic                 HOST_DOUT_VALID,
  output logic [FB_ADDR_W-1:0] FB_ADDR,
  output logic                 FB_DIN,
  output logic                 FB_WE,
  input  logic                 FB_DOUT
);
  localparam int BW = $clog2(HOST_MAX_BURST + 1);

  fb_state_t            state;
  logic [BW-1:0]        burst_cnt;
  logic                 colour;
  logic [1:0]           vld_pipe;
  logic [FB_ADDR_W-1:0] walk_addr;
  logic                 walk_last;
  logic                 accept, fill_own, host_xfer;

  assign CMD_READY = (state == IDLE);
  assign accept    = CMD_VALID & CMD_READY;

  always_comb begin
    HOST_GNT = HOST_REQ;
    if (state == FILL) HOST_GNT = HOST_REQ && (burst_cnt < BW'(HOST_MAX_BURST));
  end

  assign host_xfer = HOST_REQ & HOST_GNT;
  assign fill_own  = (state == FILL) & ~HOST_GNT;

  fb_rect_walker u_walker (
    .gclk    (CLK),
    .grst_n  (RESETN),
    .load    (accept),
    .advance (fill_own),
    .x0      (CMD_X0),
    .x1      (CMD_X1),
    .y0      (CMD_Y0),
    .y1      (CMD_Y1),
    .addr    (walk_addr),
    .last    (walk_last)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state           <= IDLE;
      burst_cnt       <= '0;
      colour          <= 1'b0;
      BUSY            <= 1'b0;
      DONE            <= 1'b0;
      FB_ADDR         <= '0;
      FB_DIN          <= 1'b0;
      FB_WE           <= 1'b0;
      vld_pipe        <= '0;
      HOST_DOUT       <= 1'b0;
      HOST_DOUT_VALID <= 1'b0;
    end else begin
      DONE  <= 1'b0;
      FB_WE <= 1'b0;

      // read data returns one cycle after the address is presented, then is registered
      vld_pipe        <= {vld_pipe[0], host_xfer & ~HOST_WE};
      HOST_DOUT_VALID <= vld_pipe[1];
      if (vld_pipe[1]) HOST_DOUT <= FB_DOUT;

      if (host_xfer) begin
        FB_ADDR <= HOST_ADDR;
        FB_DIN  <= HOST_DIN;
        FB_WE   <= HOST_WE;
      end else if (fill_own) begin
        FB_ADDR <= walk_addr;
        FB_DIN  <= colour;
        FB_WE   <= 1'b1;
      end

      // any non-host-grant cycle in FILL is a fill write or an idle request line
      if (state == FILL && host_xfer) burst_cnt <= burst_cnt + 1'b1;
      else                            burst_cnt <= '0;

      case (state)
        IDLE: if (accept) begin
          state  <= FILL;
          colour <= CMD_COLOUR;
          BUSY   <= 1'b1;
        end
        FILL: if (fill_own && walk_last) begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_rect_fill_ctrl.sv
// Directed bench for fb_rect_fill_ctrl with a 1-bit frame-buffer port-A model.
module tb_fb_rect_fill_ctrl;
  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [7:0]  CMD_X0 = '0, CMD_X1 = '0;
  logic [6:0]  CMD_Y0 = '0, CMD_Y1 = '0;
  logic        CMD_COLOUR = 1'b0;
  logic        BUSY, DONE;
  logic        HOST_REQ = 1'b0, HOST_WE = 1'b0, HOST_DIN = 1'b0;
  logic [14:0] HOST_ADDR = '0;
  logic        HOST_GNT, HOST_DOUT, HOST_DOUT_VALID;
  logic [14:0] FB_ADDR;
  logic        FB_DIN, FB_WE;
  logic        FB_DOUT = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  fb_rect_fill_ctrl #(.HOST_MAX_BURST(4)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_X0(CMD_X0), .CMD_X1(CMD_X1), .CMD_Y0(CMD_Y0), .CMD_Y1(CMD_Y1),
    .CMD_COLOUR(CMD_COLOUR), .BUSY(BUSY), .DONE(DONE),
    .HOST_REQ(HOST_REQ), .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR), .HOST_DIN(HOST_DIN),
    .HOST_GNT(HOST_GNT), .HOST_DOUT(HOST_DOUT), .HOST_DOUT_VALID(HOST_DOUT_VALID),
    .FB_ADDR(FB_ADDR), .FB_DIN(FB_DIN), .FB_WE(FB_WE), .FB_DOUT(FB_DOUT)
  );

  always #5 CLK = ~CLK;

  // Frame buffer: unwritten pixels hold a parity pattern of their address.
  bit wflag [32768];
  bit wdata [32768];
  function automatic bit pat(input logic [14:0] a);
    return ^a;
  endfunction
  function automatic bit memval(input logic [14:0] a);
    return wflag[a] ? wdata[a] : pat(a);
  endfunction
  always @(posedge CLK) begin
    if (FB_WE) begin
      wflag[FB_ADDR] <= 1'b1;
      wdata[FB_ADDR] <= FB_DIN;
    end
    FB_DOUT <= memval(FB_ADDR);
  end

  // Observation logs, sampled on the falling edge.
  logic [14:0] wr_addr[$];
  bit          wr_din[$];
  int          wr_cyc[$];
  int          done_cyc[$];
  bit          gnt_log[$];
  bit          rd_exp[$];
  int          rd_exp_cyc[$];
  bit          rd_obs[$];
  int          rd_obs_cyc[$];

  always @(negedge CLK) begin
    cyc++;
    if (FB_WE) begin
      wr_addr.push_back(FB_ADDR); wr_din.push_back(FB_DIN); wr_cyc.push_back(cyc);
    end
    if (DONE) done_cyc.push_back(cyc);
    if (BUSY) gnt_log.push_back(HOST_GNT);
    // grant edge is the next rising edge, observed at the following falling edge (cyc+1)
    if (HOST_REQ && HOST_GNT && !HOST_WE) begin
      rd_exp.push_back(memval(HOST_ADDR)); rd_exp_cyc.push_back(cyc + 1);
    end
    if (HOST_DOUT_VALID) begin
      rd_obs.push_back(HOST_DOUT); rd_obs_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    wr_addr.delete(); wr_din.delete(); wr_cyc.delete(); done_cyc.delete(); gnt_log.delete();
    rd_exp.delete(); rd_exp_cyc.delete(); rd_obs.delete(); rd_obs_cyc.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] x0, input logic [7:0] x1,
                          input logic [6:0] y0, input logic [6:0] y1, input logic c);
    CMD_X0 = x0; CMD_X1 = x1; CMD_Y0 = y0; CMD_Y1 = y1; CMD_COLOUR = c;
    CMD_VALID = 1'b1;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (BUSY && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (BUSY) begin errors++; $display("FAIL %s timeout: BUSY still 1 after %0d cycles", name, budget); end
    tick(2);
  endtask

  task automatic test_reset();
    RESETN = 1'b0; HOST_REQ = 1'b1; HOST_WE = 1'b0;
    #23;
    checks++; if (FB_WE !== 1'b0) begin errors++; $display("FAIL reset_fb_we: got %b want 0", FB_WE); end
    checks++; if (FB_ADDR !== 15'h0) begin errors++; $display("FAIL reset_fb_addr: got %h want 0000", FB_ADDR); end
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", BUSY, DONE); end
    checks++; if (HOST_DOUT_VALID !== 1'b0 || HOST_DOUT !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b%b want 00", HOST_DOUT_VALID, HOST_DOUT); end
    checks++; if (CMD_READY !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", CMD_READY); end
    checks++; if (HOST_GNT !== 1'b1) begin errors++; $display("FAIL reset_gnt_req1: got %b want 1", HOST_GNT); end
    HOST_REQ = 1'b0; #1;
    checks++; if (HOST_GNT !== 1'b0) begin errors++; $display("FAIL reset_gnt_req0: got %b want 0", HOST_GNT); end
    @(negedge CLK); RESETN = 1'b1;
    tick(2);
    clear_logs();
  endtask

  task automatic test_fill(input string name, input logic [7:0] x0, input logic [7:0] x1,
                           input logic [6:0] y0, input logic [6:0] y1);
    logic [14:0] exp_a [6];
    int c0;
    exp_a = '{15'h050A, 15'h050B, 15'h050C, 15'h060A, 15'h060B, 15'h060C};
    clear_logs();
    send_cmd(x0, x1, y0, y1, 1'b1);
    c0 = cyc;
    checks++; if (BUSY !== 1'b1 || CMD_READY !== 1'b0) begin errors++; $display("FAIL %s_busy: got busy=%b ready=%b want 1 0", name, BUSY, CMD_READY); end
    wait_idle(50, name);
    checks++;
    if (wr_addr.size() != 6) begin
      errors++; $display("FAIL %s_count: got %0d writes want 6", name, wr_addr.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wr_addr[i] !== exp_a[i] || wr_din[i] !== 1'b1) begin
          errors++; $display("FAIL %s_write%0d: got %h/%b want %h/1", name, i, wr_addr[i], wr_din[i], exp_a[i]);
        end
      end
      checks++; if (wr_cyc[0] != c0 + 2) begin errors++; $display("FAIL %s_first_latency: got cycle %0d want %0d", name, wr_cyc[0], c0 + 2); end
      checks++; if (wr_cyc[5] - wr_cyc[0] != 5) begin errors++; $display("FAIL %s_consecutive: got span %0d want 5", name, wr_cyc[5] - wr_cyc[0]); end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != wr_cyc[5]) begin
        errors++; $display("FAIL %s_done: got %0d pulses want 1 with last write at %0d", name, done_cyc.size(), wr_cyc[5]);
      end
    end
    checks++; if (CMD_READY !== 1'b1) begin errors++; $display("FAIL %s_ready_after: got %b want 1", name, CMD_READY); end
  endtask

  task automatic test_single_pixel();
    clear_logs();
    send_cmd(8'hFF, 8'hFF, 7'h7F, 7'h7F, 1'b1);
    wait_idle(20, "single");
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 15'h7FFF) begin
      errors++; $display("FAIL single_write: got %0d writes (first %h) want 1 at 7fff", wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 15'h0);
    end
    checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL single_done: got %0d pulses want 1", done_cyc.size()); end
  endtask

  task automatic test_host_write_read();
    clear_logs();
    // pattern value at 0x1234 is 1; write 0 and read it back
    HOST_REQ = 1'b1; HOST_WE = 1'b1; HOST_ADDR = 15'h1234; HOST_DIN = 1'b0;
    #1;
    checks++; if (HOST_GNT !== 1'b1) begin errors++; $display("FAIL hostwr_gnt: got %b want 1", HOST_GNT); end
    tick(1);
    HOST_REQ = 1'b0;
    checks++;
    if (FB_WE !== 1'b1 || FB_ADDR !== 15'h1234 || FB_DIN !== 1'b0) begin
      errors++; $display("FAIL hostwr_port: got we=%b addr=%h din=%b want 1 1234 0", FB_WE, FB_ADDR, FB_DIN);
    end
    tick(1);
    HOST_REQ = 1'b1; HOST_WE = 1'b0;
    tick(1);
    HOST_REQ = 1'b0;
    checks++; if (FB_WE !== 1'b0 || FB_ADDR !== 15'h1234) begin errors++; $display("FAIL hostrd_port: got we=%b addr=%h want 0 1234", FB_WE, FB_ADDR); end
    tick(1);
    checks++; if (HOST_DOUT_VALID !== 1'b0) begin errors++; $display("FAIL hostrd_early: got valid %b want 0", HOST_DOUT_VALID); end
    tick(1);
    checks++;
    if (HOST_DOUT_VALID !== 1'b1 || HOST_DOUT !== 1'b0) begin
      errors++; $display("FAIL hostrd_data: got valid=%b dout=%b want 1 0", HOST_DOUT_VALID, HOST_DOUT);
    end
    tick(1);
    checks++; if (HOST_DOUT_VALID !== 1'b0) begin errors++; $display("FAIL hostrd_pulse: got valid %b want 0", HOST_DOUT_VALID); end
  endtask

  task automatic test_host_burst();
    int bad = 0;
    int n = 0;
    clear_logs();
    send_cmd(8'd0, 8'd3, 7'd0, 7'd1, 1'b1);
    HOST_REQ = 1'b1; HOST_WE = 1'b0;
    // reads target row 100, which no fill in this bench touches before the clear
    while (BUSY && n < 200) begin
      HOST_ADDR = {7'd100, 8'(n * 7)};
      @(posedge CLK); #1;
      n++;
    end
    HOST_REQ = 1'b0;
    tick(4);
    checks++; if (gnt_log.size() != 40) begin errors++; $display("FAIL burst_len: got %0d fill cycles want 40", gnt_log.size()); end
    for (int i = 0; i < gnt_log.size(); i++) if (gnt_log[i] !== ((i % 5) != 4)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL burst_pattern: got %0d wrong grant slots want 0", bad); end
    checks++;
    if (wr_addr.size() != 8 || wr_addr[0] !== 15'h0000 || wr_addr[7] !== 15'h0103) begin
      errors++; $display("FAIL burst_fill: got %0d writes want 8 from 0000 to 0103", wr_addr.size());
    end
    checks++; if (rd_obs.size() != 32 || rd_exp.size() != 32) begin errors++; $display("FAIL burst_reads: got %0d valids for %0d grants want 32", rd_obs.size(), rd_exp.size()); end
    bad = 0;
    for (int i = 0; i < rd_obs.size() && i < rd_exp.size(); i++)
      if (rd_obs[i] !== rd_exp[i] || rd_obs_cyc[i] - rd_exp_cyc[i] != 2) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL burst_read_data: got %0d bad reads want 0", bad); end
  endtask

  task automatic test_full_clear();
    int bad = 0;
    int n;
    clear_logs();
    send_cmd(8'd0, 8'd255, 7'd0, 7'd127, 1'b0);
    wait_idle(40000, "clear");
    n = wr_addr.size();
    checks++; if (n != 32768) begin errors++; $display("FAIL clear_count: got %0d writes want 32768", n); end
    if (n == 32768) begin
      for (int i = 0; i < n; i++) if (wr_addr[i] !== 15'(i) || wr_din[i] !== 1'b0) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL clear_order: got %0d out-of-order writes want 0", bad); end
      checks++; if (wr_cyc[n-1] - wr_cyc[0] != 32767) begin errors++; $display("FAIL clear_span: got %0d want 32767", wr_cyc[n-1] - wr_cyc[0]); end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != wr_cyc[n-1]) begin
        errors++; $display("FAIL clear_done: got %0d pulses want 1 with last write", done_cyc.size());
      end
    end
  endtask

  task automatic test_reset_midfill();
    clear_logs();
    send_cmd(8'd0, 8'd255, 7'd0, 7'd127, 1'b1);
    tick(10);
    checks++; if (FB_WE !== 1'b1) begin errors++; $display("FAIL midfill_running: got we %b want 1", FB_WE); end
    #2 RESETN = 1'b0;
    #1;
    checks++;
    if (FB_WE !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++; $display("FAIL midfill_abort: got we=%b busy=%b done=%b want 0 0 0", FB_WE, BUSY, DONE);
    end
    @(negedge CLK);
    RESETN = 1'b1;
    clear_logs();
    tick(20);
    checks++; if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL midfill_idle: got ready=%b busy=%b want 1 0", CMD_READY, BUSY); end
    checks++; if (wr_addr.size() != 0 || done_cyc.size() != 0) begin errors++; $display("FAIL midfill_quiet: got %0d writes %0d dones want 0 0", wr_addr.size(), done_cyc.size()); end
  endtask

  initial begin
    test_reset();
    test_fill("fill", 8'd10, 8'd12, 7'd5, 7'd6);
    test_fill("swapped", 8'd12, 8'd10, 7'd6, 7'd5);
    test_single_pixel();
    test_host_write_read();
    test_host_burst();
    test_full_clear();
    test_reset_midfill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
